ks_multiword_add_seq: RTL and testbench

- Multi-cycle sequencer that adds two WORDS×WIDTH-bit operands by driving an external WIDTH-bit combinational prefix adder one word per cycle, least-significant word first.
- Carry is chained between words through an internal carry register.
- Sits directly upstream of the PPA Kogge-Stone adder: supplies its A/B/cin and consumes its S/cout.
- Uses a valid/ready handshake on both the operand and result sides.

---
 rtl/ks_multiword_add_seq.sv | 113 +++++++++++
 tb/tb_ks_multiword_add_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_multiword_add_seq.sv
// Multi-word adder sequencer: feeds an external WIDTH-bit prefix adder one
// word per cycle, least-significant word first, chaining the carry through
// carry_reg. Operands are accepted and results returned over valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1, adder inputs held at 0
// RUN   | word idx on the adder, sum word and carry captured each edge
// DONE  | result presented on out_sum/out_cout until out_ready
module ks_multiword_add_seq #(
    parameter int WIDTH = 19,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_cout
);

    // Index needs at least one bit even for a single-word build.
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry_reg;
    logic             cout_reg;
    logic [WIDTH-1:0] a_w [WORDS];
    logic [WIDTH-1:0] b_w [WORDS];
    logic [WIDTH-1:0] s_w [WORDS];

    // Sequencer: operand capture, per-word sum/carry capture, result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                a_w[k] <= '0;
                b_w[k] <= '0;
                s_w[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < WORDS; k++) begin
                            a_w[k] <= in_a[k*WIDTH +: WIDTH];
                            b_w[k] <= in_b[k*WIDTH +: WIDTH];
                        end
                        carry_reg <= in_cin;
                        idx       <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    s_w[idx]  <= add_s;
                    carry_reg <= add_cout;
                    if (idx == LAST) begin
                        cout_reg <= add_cout;
                        state    <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags and adder drive decode straight from registered state;
    // the adder sees zeros whenever no word is in flight.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == S_RUN) begin
            add_a   = a_w[idx];
            add_b   = b_w[idx];
            add_cin = carry_reg;
        end
    end

    assign out_cout = cout_reg;

    for (genvar k = 0; k < WORDS; k++) begin : g_pack
        assign out_sum[k*WIDTH +: WIDTH] = s_w[k];
    end

endmodule

// File: tb/tb_ks_multiword_add_seq.sv
// Directed and random bench for ks_multiword_add_seq with a behavioural
// prefix adder attached; a second instance covers the single-word build.
module tb_ks_multiword_add_seq;

    localparam int W  = 19;
    localparam int N  = 4;
    localparam int OW = W * N;

    logic          clk;
    logic          rst;
    logic          in_valid, in_ready, in_cin;
    logic [OW-1:0] in_a, in_b, out_sum;
    logic          out_valid, out_ready, out_cout;
    logic [W-1:0]  add_a, add_b, add_s;
    logic          add_cin, add_cout;

    logic          in_valid1, in_ready1, in_cin1;
    logic [W-1:0]  in_a1, in_b1, out_sum1;
    logic          out_valid1, out_ready1, out_cout1;
    logic [W-1:0]  add_a1, add_b1, add_s1;
    logic          add_cin1, add_cout1;

    int tests_run;
    int tests_failed;

    ks_multiword_add_seq #(.WIDTH(W), .WORDS(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    ks_multiword_add_seq #(.WIDTH(W), .WORDS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_cout(out_cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_s(add_s1), .add_cout(add_cout1)
    );

    // behavioural stand-ins for the external prefix adders
    assign {add_cout, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {{W{1'b0}}, add_cin1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        tests_run++;
        if ({in_ready, out_valid, out_cout, add_cin} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b need 1000", {in_ready, out_valid, out_cout, add_cin});
        end
        tests_run++;
        if ({out_sum, add_a, add_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: sum %h add_a %h add_b %h need 0", out_sum, add_a, add_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_ripple();
        accept({OW{1'b1}}, '0, 1'b1);
        for (int k = 0; k < N; k++) begin
            tests_run++;
            if (add_cin !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL ripple_cin[%0d]: add_cin %b out_valid %b need 1 0", k, add_cin, out_valid);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== '0 || out_cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL ripple_result: valid %b sum %h cout %b need 1 0 1", out_valid, out_sum, out_cout);
        end
        release_out();
    endtask

    task automatic test_small();
        logic [W-1:0] exp_a;
        accept(76'd1, 76'd1, 1'b0);
        for (int k = 0; k < N; k++) begin
            exp_a = (k == 0) ? 19'd1 : 19'd0;
            tests_run++;
            if (add_cin !== 1'b0 || add_a !== exp_a) begin
                tests_failed++;
                $display("FAIL small_drive[%0d]: add_a %h add_cin %b need %h 0", k, add_a, add_cin, exp_a);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 76'd2 || out_cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL small_result: valid %b sum %h cout %b need 1 2 0", out_valid, out_sum, out_cout);
        end
        release_out();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== '0) begin
            tests_failed++;
            $display("FAIL small_idle: valid %b ready %b add_a %h need 0 1 0", out_valid, in_ready, add_a);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        accept(76'd1000000, 76'd2345678, 1'b1);
        repeat (N) tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_a = 76'd5; in_b = 76'd5; in_cin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 76'd3345679 || out_cout !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid %b ready %b sum %h cout %b need 1 0 330d0f 0",
                         i, out_valid, in_ready, out_sum, out_cout);
            end
            tick();
        end
        in_valid = 1'b0;
        release_out();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: valid %b ready %b need 0 1", out_valid, in_ready);
        end
        repeat (N + 1) tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 76'd3345679) begin
            tests_failed++;
            $display("FAIL bp_no_accept: valid %b ready %b sum %h need 0 1 330d0f", out_valid, in_ready, out_sum);
        end
    endtask

    task automatic test_reset_mid();
        accept(76'h123456789ABCDEF0123, 76'h0, 1'b0);
        tests_run++;
        if (add_a !== 19'h70123) begin
            tests_failed++;
            $display("FAIL mid_word0: add_a %h need 70123", add_a);
        end
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || add_a !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid %b ready %b sum %h add_a %h need 0 1 0 0",
                     out_valid, in_ready, out_sum, add_a);
        end
        rst = 1'b0;
        tick();
        accept(76'd5, 76'd7, 1'b1);
        repeat (N) tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sum !== 76'd13 || out_cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_after: valid %b sum %h cout %b need 1 d 0", out_valid, out_sum, out_cout);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [OW-1:0] a, b;
        logic          c;
        logic [OW:0]   exp_r;
        int            n;
        int            pass;
        pass = 0;
        for (int t = 0; t < 50; t++) begin
            a = {$urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom};
            c = 1'($urandom_range(0, 1));
            if (t == 0) begin a = {OW{1'b1}}; b = {OW{1'b1}}; c = 1'b1; end
            exp_r = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, c};
            accept(a, b, c);
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            tests_run++;
            if (out_valid !== 1'b1 || {out_cout, out_sum} !== exp_r || n != N) begin
                tests_failed++;
                $display("FAIL random[%0d]: valid %b got %h need %h cycles %0d need %0d",
                         t, out_valid, {out_cout, out_sum}, exp_r, n, N);
            end else begin
                pass++;
            end
            release_out();
        end
        $display("[TB] random: %0d/50 passed", pass);
    endtask

    task automatic test_words1();
        in_a1 = 19'h7FFFF; in_b1 = 19'h00001; in_cin1 = 1'b0; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tests_run++;
        if (out_valid1 !== 1'b0 || add_a1 !== 19'h7FFFF || add_b1 !== 19'h00001) begin
            tests_failed++;
            $display("FAIL w1_run: valid %b add_a %h add_b %h need 0 7ffff 00001", out_valid1, add_a1, add_b1);
        end
        tick();
        tests_run++;
        if (out_valid1 !== 1'b1 || out_sum1 !== '0 || out_cout1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w1_result: valid %b sum %h cout %b need 1 0 1", out_valid1, out_sum1, out_cout1);
        end
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        tests_run++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w1_release: valid %b ready %b need 0 1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
        test_reset();
        test_full_ripple();
        test_small();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_words1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
